// File: rtl/mmio_tap_ram.sv
// Single-port data RAM with memory-mapped tap words exposed as live outputs.
// Storage is split into byte lanes. Each lane owns its slice of the array and
// its slice of every tap register. Taps mirror their words by replaying the
// same byte-enabled writes, so no read-modify-write of the array is needed.

module mmio_tap_ram_lane #(
  parameter int DEPTH    = 4096,
  parameter int IDX_W    = 12,
  parameter int NUM_TAPS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic                     re,
  input  logic                     rz,
  input  logic [IDX_W-1:0]         idx,
  input  logic [7:0]               wd,
  input  logic [NUM_TAPS-1:0]      tap_hit,
  output logic [7:0]               q,
  output logic [NUM_TAPS-1:0][7:0] tap
);
  logic [7:0] mem [DEPTH];

  // Lane storage: no reset, so it infers as block RAM; the clear sweep zeroes it
  always_ff @(posedge clk)
    if (we) mem[idx] <= wd;

  // Registered read; out-of-range reads return zero, and q holds when there is no read
  always_ff @(posedge clk)
    if (!reset_n)  q <= 8'h00;
    else if (re)   q <= rz ? 8'h00 : mem[idx];

  // Tap mirror: follows the byte writes aimed at its word
  always_ff @(posedge clk)
    if (!reset_n) tap <= '0;
    else
      for (int k = 0; k < NUM_TAPS; k++)
        if (tap_hit[k] && we) tap[k] <= wd;
endmodule

module mmio_tap_ram #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096,
  parameter int NUM_TAPS      = 4,
  parameter int TAP_BASE      = 10
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wEn,
  input  logic [DATA_WIDTH/8-1:0]        byteEn,
  input  logic [ADDRESS_WIDTH-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]          dataIn,
  output logic [DATA_WIDTH-1:0]          dataOut,
  output logic                           rdValid,
  output logic                           busy,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] tapData,
  output logic [NUM_TAPS-1:0]            tapUpdate
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]             state;
  logic [IDX_W-1:0]       clr_addr;
  logic                   clearing, idle, in_range, wr, rd;
  logic [IDX_W-1:0]       idx;
  logic [NUM_TAPS-1:0]    tap_hit;
  logic [LANES-1:0][7:0]  lane_q;
  logic [LANES-1:0][NUM_TAPS-1:0][7:0] lane_tap;

  assign clearing = (state == ST_CLEAR);
  assign idle     = (state == ST_IDLE);
  assign busy     = clearing;
  // Widen by one bit so DEPTH == 2**ADDRESS_WIDTH does not truncate to zero
  assign in_range = ({1'b0, addr} < (ADDRESS_WIDTH+1)'(DEPTH));
  assign wr       = idle & wEn & in_range;
  assign rd       = idle & ~wEn;
  assign idx      = clearing ? clr_addr : addr[IDX_W-1:0];

  // Clear sweep: zero one word per cycle from address 0, then go idle
  always_ff @(posedge clk)
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (clearing) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == IDX_W'(DEPTH-1)) state <= ST_IDLE;
    end

  // Read valid and tap strobes; a write with no byte enabled raises no strobe
  always_ff @(posedge clk)
    if (!reset_n) begin
      rdValid   <= 1'b0;
      tapUpdate <= '0;
    end else begin
      rdValid   <= rd;
      tapUpdate <= tap_hit & {NUM_TAPS{|byteEn}};
    end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_hit
    localparam int TA = TAP_BASE + k;
    assign tap_hit[k] = wr && (addr == ADDRESS_WIDTH'(TA));
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mmio_tap_ram_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_TAPS(NUM_TAPS)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (clearing | (wr & byteEn[i])),
      .re      (rd),
      .rz      (~in_range),
      .idx     (idx),
      .wd      (clearing ? 8'h00 : dataIn[8*i +: 8]),
      .tap_hit (tap_hit),
      .q       (lane_q[i]),
      .tap     (lane_tap[i])
    );
    assign dataOut[8*i +: 8] = lane_q[i];
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      assign tapData[k*DATA_WIDTH + 8*i +: 8] = lane_tap[i][k];
    end
  end
endmodule

// File: tb/tb_mmio_tap_ram.sv
// Bench for mmio_tap_ram: directed scenarios plus random traffic, every
// cycle compared against a word-level model of the memory and the taps.
module tb_mmio_tap_ram;
  localparam int DW = 32, AW = 7, DEPTH = 64, NT = 4, TB = 10;

  logic            clk = 0;
  logic            reset_n, wEn;
  logic [3:0]      byteEn;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dataIn, dataOut;
  logic            rdValid, busy;
  logic [NT*DW-1:0] tapData;
  logic [NT-1:0]   tapUpdate;

  mmio_tap_ram #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH),
                 .NUM_TAPS(NT), .TAP_BASE(TB)) dut (
    .clk(clk), .reset_n(reset_n), .wEn(wEn), .byteEn(byteEn), .addr(addr),
    .dataIn(dataIn), .dataOut(dataOut), .rdValid(rdValid), .busy(busy),
    .tapData(tapData), .tapUpdate(tapUpdate));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_tap [NT];
  logic [31:0] m_dout;
  logic        m_rv;
  logic [3:0]  m_upd;
  int          m_clr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, input logic we, input logic [3:0] be,
                       input int a, input logic [31:0] d);
    if (rst) begin
      foreach (m_mem[j]) m_mem[j] = 0;
      foreach (m_tap[j]) m_tap[j] = 0;
      m_dout = 0; m_rv = 0; m_upd = 0; m_clr = DEPTH;
    end else if (m_clr > 0) begin
      m_clr--; m_rv = 0; m_upd = 0;
    end else if (we) begin
      m_rv = 0; m_upd = 0;
      if (a < DEPTH) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) m_mem[a][8*l +: 8] = d[8*l +: 8];
        if (a >= TB && a < TB + NT && be != 0) begin
          m_tap[a-TB] = m_mem[a];
          m_upd = 4'(1 << (a-TB));
        end
      end
    end else begin
      m_dout = (a < DEPTH) ? m_mem[a] : 32'h0;
      m_rv = 1; m_upd = 0;
    end
  endtask

  // One clock: drive, advance model on the edge, compare just after it
  task automatic cyc(input logic rst, input logic we, input logic [3:0] be,
                     input int a, input logic [31:0] d);
    reset_n = ~rst; wEn = we; byteEn = be; addr = AW'(a); dataIn = d;
    @(posedge clk);
    model(rst, we, be, a, d);
    #1;
    chk("dataOut", dataOut, m_dout);
    chk("rdValid", 32'(rdValid), 32'(m_rv));
    chk("busy", 32'(busy), 32'(m_clr > 0));
    chk("tapUpdate", 32'(tapUpdate), 32'(m_upd));
    for (int k = 0; k < NT; k++) chk($sformatf("tapData%0d", k), tapData[k*DW +: DW], m_tap[k]);
  endtask

  // Counts busy cycles while hammering a write that must be ignored
  task automatic sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      cyc(0, 1, 4'hF, 5, 32'hFFFF_FFFF);
      n++;
    end
  endtask

  int n;
  logic [31:0] r;

  initial begin
    // 1: reset, sweep length, ignored writes during sweep
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 4'hF, 5, 32'h1234);
    sweep(n);
    chk("sweep_len", 32'(n), 32'(DEPTH));
    cyc(0, 0, 0, 5, 0);
    chk("rd5_after_sweep", dataOut, 32'h0);
    chk("rd5_valid", 32'(rdValid), 32'h1);

    // 2: byte-enable merge
    cyc(0, 1, 4'b1111, 3, 32'hAABBCCDD);
    cyc(0, 1, 4'b0101, 3, 32'h11223344);
    cyc(0, 0, 4'b0000, 3, 0);
    chk("merge", dataOut, 32'hAA22CC44);
    cyc(0, 1, 4'b0000, 0, 0);
    chk("rv_single", 32'(rdValid), 32'h0);
    chk("dout_hold", dataOut, 32'hAA22CC44);

    // 3: tap write and one-cycle strobe
    cyc(0, 1, 4'hF, 11, 32'h3E8);
    chk("tap1", tapData[1*DW +: DW], 32'h3E8);
    chk("tap1_upd", 32'(tapUpdate), 32'b0010);
    cyc(0, 0, 4'hF, 11, 0);
    chk("tap1_upd_off", 32'(tapUpdate), 32'b0000);

    // 4: byteEn=0 no-op on a tap, boundary addresses
    cyc(0, 1, 4'b0000, 12, 32'hDEAD_BEEF);
    chk("tap2_noop", 32'(tapUpdate), 32'h0);
    cyc(0, 1, 4'hF, DEPTH-1, 32'hCAFE_0001);
    cyc(0, 0, 0, DEPTH-1, 0);
    chk("rd_last", dataOut, 32'hCAFE_0001);
    cyc(0, 1, 4'hF, DEPTH, 32'h5555_5555);
    cyc(0, 0, 0, DEPTH, 0);
    chk("rd_oor", dataOut, 32'h0);
    chk("rd_oor_valid", 32'(rdValid), 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("oor_no_alias", dataOut, 32'h0);

    // 5: reset mid-operation reruns the sweep
    cyc(0, 1, 4'hF, 10, 32'h55);
    chk("tap0", tapData[DW-1:0], 32'h55);
    cyc(1, 0, 0, 0, 0);
    chk("rst_tap0", tapData[DW-1:0], 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    sweep(n);
    chk("sweep_len2", 32'(n), 32'(DEPTH));
    cyc(0, 0, 0, 10, 0);
    chk("rd10_zero", dataOut, 32'h0);
    cyc(0, 0, 0, 3, 0);
    chk("rd3_zero", dataOut, 32'h0);

    // 6: alternating write/read on one word
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 4'hF, 7, 32'h100 + i);
      cyc(0, 0, 0, 7, 0);
      chk("raw", dataOut, 32'h100 + i);
    end

    // Random traffic, biased toward taps and out-of-range addresses
    for (int i = 0; i < 600; i++) begin
      int a;
      case ($urandom_range(0, 3))
        0: a = $urandom_range(TB, TB + NT - 1);
        1: a = $urandom_range(DEPTH, 127);
        default: a = $urandom_range(0, 15);
      endcase
      r = $urandom;
      cyc(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_tap_ram.md
Name: mmio_tap_ram

Overview:
Parametrised single-port synchronous RAM used as the processor data memory. It exposes NUM_TAPS memory-mapped words as live parallel outputs, for example motor position and speed setpoints consumed by the motor driver. Each tap carries a one-cycle update strobe. Writes support byte enables. After reset the block runs a hardware clear sweep, so memory is zeroed without relying on simulation initialisation.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDRESS_WIDTH, 12, address bus width
DEPTH, 4096, number of words; DEPTH <= 2**ADDRESS_WIDTH
NUM_TAPS, 4, number of contiguous memory-mapped tap words
TAP_BASE, 10, word address of tap 0; TAP_BASE+NUM_TAPS <= DEPTH

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
wEn  in  1  write request; when low, the cycle is a read
byteEn  in  DATA_WIDTH/8  per-byte write enable; lane i covers bits [8i+7:8i]
addr  in  ADDRESS_WIDTH  word address
dataIn  in  DATA_WIDTH  write data
dataOut  out  DATA_WIDTH  registered read data
rdValid  out  1  high for the one cycle in which dataOut holds a fresh read result
busy  out  1  high while the clear sweep runs; all requests are ignored
tapData  out  NUM_TAPS*DATA_WIDTH  tap k at bits [k*DATA_WIDTH +: DATA_WIDTH] mirrors word TAP_BASE+k
tapUpdate  out  NUM_TAPS  bit k pulses for 1 cycle when word TAP_BASE+k is written

Behaviour:
- Reset (reset_n=0 sampled at posedge):
  - dataOut=0, rdValid=0, tapData=0, tapUpdate=0, busy=1.
  - Clear counter=0, FSM enters CLEAR.
  - Reset asserted mid-sweep or mid-operation restarts the sweep from address 0.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to word clrAddr, then clrAddr++.
  - In the cycle that writes DEPTH-1, the next state is IDLE.
  - busy is high for exactly DEPTH cycles after reset release and falls on the edge that enters IDLE.
  - wEn, addr, dataIn and byteEn are ignored. rdValid stays 0 and tapUpdate stays 0.
- IDLE, write (wEn=1, addr<DEPTH):
  - For each lane i with byteEn[i]=1, the word's lane i takes dataIn lane i; other lanes keep their value.
  - dataOut holds its value; rdValid=0 next cycle.
- IDLE, read (wEn=0):
  - Next cycle, dataOut=mem[addr] and rdValid=1. Latency is 1 cycle.
  - byteEn is ignored on reads.
  - Back-to-back reads give one result per cycle.
- Read-after-write to the same address on the next cycle returns the newly written (merged) value.
- Out-of-range address (addr>=DEPTH):
  - Writes are dropped with no tap effect.
  - Reads return dataOut=0 with rdValid=1.
- Taps:
  - A write in IDLE to TAP_BASE+k with any byteEn bit set drives, on the next cycle, tapData[k] = merged word and tapUpdate[k]=1 for exactly that cycle.
  - A write with byteEn=0 is a no-op: no memory change, no pulse.
  - Taps hold their value otherwise.
  - Reads never pulse tapUpdate.
- Only one address is accessed per cycle, so at most one tapUpdate bit is high in any cycle.
- Addresses are unsigned. There is no wrap-around; addresses outside the valid range are handled as out-of-range above.

Test Plan:
1. DEPTH=64. Release reset, hold wEn=1 addr=5 dataIn=0xFFFFFFFF throughout -> busy high exactly 64 cycles, no write takes effect. After busy falls, reading addr 5 gives 0 with rdValid=1.
2. Write addr 3 data 0xAABBCCDD byteEn=1111, then write 0x11223344 byteEn=0101, then read addr 3 -> dataOut=0xAA22CC44 one cycle after the read; rdValid high for that single cycle.
3. Write addr 11 (tap 1) data 0x000003E8 byteEn=1111 -> next cycle tapData[1]=0x3E8 and tapUpdate=0010 for one cycle; other taps remain 0.
4. Write addr 12 with byteEn=0000 -> tapUpdate stays 0000 and tapData[2] is unchanged. Then read addr 4095 at DEPTH=4096 -> valid data; read addr 4096 with ADDRESS_WIDTH=13 -> dataOut=0, rdValid=1.
5. Pulse reset_n low for 1 cycle after tap 0 was written 0x55 -> tapData=0, dataOut=0, busy=1, and the sweep reruns. Reading addr 10 after busy falls gives 0.
6. Alternate write/read every cycle on addr 7 with incrementing data -> each read returns the value from the immediately preceding write.
